// File: rtl/alu_sequencer_if.sv
// Request, ALU-side and response signals of the ALU sequencer.
// The slave modport is the sequencer's view of these signals; the master modport is the other side.
interface alu_sequencer_if;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_op;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [12:0] alu_control;
   logic [63:0] alu_c;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_hi;
   logic [31:0] rsp_lo;
   logic        rsp_err;
   logic        busy;

   modport slave (
      input  req_valid, req_op, req_a, req_b, alu_c, rsp_ready,
      output req_ready, alu_a, alu_b, alu_control, rsp_valid, rsp_hi, rsp_lo, rsp_err, busy
   );

   modport master (
      output req_valid, req_op, req_a, req_b, alu_c, rsp_ready,
      input  req_ready, alu_a, alu_b, alu_control, rsp_valid, rsp_hi, rsp_lo, rsp_err, busy
   );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle controller for the shared 32-bit ALU: accepts one op, holds the ALU inputs for the op's
// settle time, captures the 64-bit result into Z and returns it over a valid/ready response port.
module alu_sequencer #(
   parameter int unsigned MUL_CYCLES = 3,
   parameter int unsigned DIV_CYCLES = 4
) (
   input logic          clk,
   input logic          clr_n,
   alu_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [3:0] OP_MUL  = 4'd4;
   localparam logic [3:0] OP_DIV  = 4'd5;
   localparam logic [3:0] OP_LAST = 4'd12;
   localparam logic [5:0] MUL_CNT = 6'(MUL_CYCLES);
   localparam logic [5:0] DIV_CNT = 6'(DIV_CYCLES);

   state_t      state_r;
   state_t      state_nxt_s;
   logic [3:0]  op_r;
   logic [3:0]  op_nxt_s;
   logic [31:0] a_r;
   logic [31:0] a_nxt_s;
   logic [31:0] b_r;
   logic [31:0] b_nxt_s;
   logic [5:0]  cnt_r;
   logic [5:0]  cnt_nxt_s;
   logic [63:0] z_r;
   logic [63:0] z_nxt_s;
   logic        err_r;
   logic        err_nxt_s;
   logic        req_ready_r;
   logic        rsp_valid_r;
   logic        busy_r;
   logic [12:0] alu_control_r;

   function automatic logic [12:0] op_onehot(input logic [3:0] op);
      logic [12:0] sel;
      if (op <= OP_LAST) begin
         sel = 13'd1 << op;
      end else begin
         sel = 13'd0;
      end
      return sel;
   endfunction

   function automatic logic op_is_error(input logic [3:0] op, input logic [31:0] b);
      return (op > OP_LAST) || ((op == OP_DIV) && (b == 32'd0));
   endfunction

   // Next-state and datapath-register updates for the IDLE/EXEC/RESP sequence.
   always_comb begin
      state_nxt_s = state_r;
      op_nxt_s    = op_r;
      a_nxt_s     = a_r;
      b_nxt_s     = b_r;
      cnt_nxt_s   = cnt_r;
      z_nxt_s     = z_r;
      err_nxt_s   = err_r;
      case (state_r)
         IDLE: begin
            if (bus.req_valid) begin
               op_nxt_s = bus.req_op;
               a_nxt_s  = bus.req_a;
               b_nxt_s  = bus.req_b;
               if (op_is_error(bus.req_op, bus.req_b)) begin
                  z_nxt_s     = 64'd0;
                  err_nxt_s   = 1'b1;
                  cnt_nxt_s   = 6'd0;
                  state_nxt_s = RESP;
               end else if (bus.req_op == OP_MUL) begin
                  cnt_nxt_s   = MUL_CNT;
                  state_nxt_s = EXEC;
               end else if (bus.req_op == OP_DIV) begin
                  cnt_nxt_s   = DIV_CNT;
                  state_nxt_s = EXEC;
               end else begin
                  cnt_nxt_s   = 6'd0;
                  state_nxt_s = EXEC;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         EXEC: begin
            if (cnt_r != 6'd0) begin
               cnt_nxt_s = cnt_r - 6'd1;
            end else begin
               z_nxt_s     = bus.alu_c;
               err_nxt_s   = 1'b0;
               state_nxt_s = RESP;
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = RESP;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State, operand, counter and Z registers; port outputs are registered from the next state.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_r       <= IDLE;
         op_r          <= 4'd0;
         a_r           <= 32'd0;
         b_r           <= 32'd0;
         cnt_r         <= 6'd0;
         z_r           <= 64'd0;
         err_r         <= 1'b0;
         req_ready_r   <= 1'b1;
         rsp_valid_r   <= 1'b0;
         busy_r        <= 1'b0;
         alu_control_r <= 13'd0;
      end else begin
         state_r       <= state_nxt_s;
         op_r          <= op_nxt_s;
         a_r           <= a_nxt_s;
         b_r           <= b_nxt_s;
         cnt_r         <= cnt_nxt_s;
         z_r           <= z_nxt_s;
         err_r         <= err_nxt_s;
         req_ready_r   <= (state_nxt_s == IDLE);
         rsp_valid_r   <= (state_nxt_s == RESP);
         busy_r        <= (state_nxt_s != IDLE);
         alu_control_r <= (state_nxt_s == EXEC) ? op_onehot(op_nxt_s) : 13'd0;
      end
   end

   assign bus.req_ready   = req_ready_r;
   assign bus.alu_a       = a_r;
   assign bus.alu_b       = b_r;
   assign bus.alu_control = alu_control_r;
   assign bus.rsp_valid   = rsp_valid_r;
   assign bus.rsp_hi      = z_r[63:32];
   assign bus.rsp_lo      = z_r[31:0];
   assign bus.rsp_err     = err_r;
   assign bus.busy        = busy_r;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed cases plus randomized ops against a reference
// model; the bench also plays the shared ALU driven by the sequencer's one-hot control.
module tb_alu_sequencer;

   localparam int MUL_CYCLES = 3;
   localparam int DIV_CYCLES = 4;

   logic clk;
   logic clr_n;
   int   checks;
   int   failures;

   alu_sequencer_if bus ();

   alu_sequencer #(
      .MUL_CYCLES(MUL_CYCLES),
      .DIV_CYCLES(DIV_CYCLES)
   ) dut (
      .clk  (clk),
      .clr_n(clr_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] alu_fn(input int op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0]        r;
      logic signed [31:0] sa;
      int                 sh;
      sh = int'(b[4:0]);
      sa = a;
      case (op)
         0:  return {32'd0, a & b};
         1:  return {32'd0, a | b};
         2:  return 64'(a) + 64'(b);
         3:  return {32'd0, a - b};
         4:  return 64'(a) * 64'(b);
         5:  return (b == 32'd0) ? 64'd0 : {a % b, a / b};
         6:  return {32'd0, a >> sh};
         7:  begin r = sa >>> sh; return {32'd0, r}; end
         8:  return {32'd0, a << sh};
         9:  begin r = (a >> sh) | (a << (32 - sh)); return {32'd0, r}; end
         10: begin r = (a << sh) | (a >> (32 - sh)); return {32'd0, r}; end
         11: return {32'd0, 32'd0 - a};
         12: return {32'd0, ~a};
         default: return 64'd0;
      endcase
   endfunction

   // Shared ALU: responds only to a one-hot control word.
   logic [63:0] alu_res;
   always_comb begin
      alu_res = 64'd0;
      for (int i = 0; i < 13; i++) begin
         if (bus.alu_control == (13'd1 << i)) alu_res = alu_fn(i, bus.alu_a, bus.alu_b);
      end
      bus.alu_c = alu_res;
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, obs, exp);
      end
   endtask

   // Issue one op from an idle negedge, follow it through EXEC and RESP, finish back in IDLE.
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
      logic        err;
      logic [63:0] res;
      int          extra;
      err   = (op > 4'd12) || ((op == 4'd5) && (b == 32'd0));
      res   = err ? 64'd0 : alu_fn(int'(op), a, b);
      extra = (op == 4'd4) ? MUL_CYCLES : (op == 4'd5) ? DIV_CYCLES : 0;
      check_eq("idle_req_ready", 64'(bus.req_ready), 64'd1);
      check_eq("idle_alu_control", 64'(bus.alu_control), 64'd0);
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_a     = a;
      bus.req_b     = b;
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.req_op    = 4'($urandom);
      bus.req_a     = $urandom;
      bus.req_b     = $urandom;
      if (!err) begin
         for (int i = 0; i <= extra; i++) begin
            check_eq("exec_alu_control", 64'(bus.alu_control), 64'(13'd1 << op));
            check_eq("exec_alu_a", 64'(bus.alu_a), 64'(a));
            check_eq("exec_alu_b", 64'(bus.alu_b), 64'(b));
            check_eq("exec_rsp_valid", 64'(bus.rsp_valid), 64'd0);
            check_eq("exec_req_ready", 64'(bus.req_ready), 64'd0);
            check_eq("exec_busy", 64'(bus.busy), 64'd1);
            @(negedge clk);
         end
      end
      for (int i = 0; i <= hold; i++) begin
         check_eq("rsp_valid", 64'(bus.rsp_valid), 64'd1);
         check_eq("rsp_hi", 64'(bus.rsp_hi), 64'(res[63:32]));
         check_eq("rsp_lo", 64'(bus.rsp_lo), 64'(res[31:0]));
         check_eq("rsp_err", 64'(bus.rsp_err), 64'(err));
         check_eq("rsp_alu_control", 64'(bus.alu_control), 64'd0);
         check_eq("rsp_req_ready", 64'(bus.req_ready), 64'd0);
         if (i < hold) begin
            bus.req_valid = 1'b1;
            bus.req_op    = 4'd2;
            @(negedge clk);
         end
      end
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      check_eq("post_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      check_eq("post_req_ready", 64'(bus.req_ready), 64'd1);
      check_eq("post_busy", 64'(bus.busy), 64'd0);
   endtask

   initial begin
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      checks        = 0;
      failures      = 0;
      clr_n         = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_op    = 4'd0;
      bus.req_a     = 32'd0;
      bus.req_b     = 32'd0;
      bus.rsp_ready = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("rst_req_ready", 64'(bus.req_ready), 64'd1);
      check_eq("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      check_eq("rst_busy", 64'(bus.busy), 64'd0);
      check_eq("rst_alu_control", 64'(bus.alu_control), 64'd0);
      check_eq("rst_z", {bus.rsp_hi, bus.rsp_lo}, 64'd0);
      check_eq("rst_err", 64'(bus.rsp_err), 64'd0);
      clr_n = 1'b1;
      @(negedge clk);

      run_op(4'd2, 32'hFFFF_FFFF, 32'h0000_0001, 0);
      run_op(4'd4, 32'h0001_0000, 32'h0001_0000, 0);
      run_op(4'd5, 32'h0000_0007, 32'h0000_0000, 0);
      run_op(4'd14, 32'h1234_5678, 32'h9ABC_DEF0, 0);
      run_op(4'd0, 32'h0000_F0F0, 32'h0000_FF00, 0);
      run_op(4'd3, 32'h0000_0005, 32'h0000_0007, 5);
      run_op(4'd5, 32'd100, 32'd7, 1);

      // Reset in the second EXEC cycle of a DIV must abort it with no response.
      bus.req_valid = 1'b1;
      bus.req_op    = 4'd5;
      bus.req_a     = 32'd100;
      bus.req_b     = 32'd7;
      @(negedge clk);
      bus.req_valid = 1'b0;
      @(negedge clk);
      check_eq("pre_abort_busy", 64'(bus.busy), 64'd1);
      #2 clr_n = 1'b0;
      #1;
      check_eq("abort_busy", 64'(bus.busy), 64'd0);
      check_eq("abort_alu_control", 64'(bus.alu_control), 64'd0);
      check_eq("abort_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      @(negedge clk);
      clr_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check_eq("after_abort_rsp_valid", 64'(bus.rsp_valid), 64'd0);
         check_eq("after_abort_req_ready", 64'(bus.req_ready), 64'd1);
      end

      for (int n = 0; n < 60; n++) begin
         op = 4'($urandom_range(0, 15));
         a  = $urandom;
         b  = $urandom;
         if ($urandom_range(0, 3) == 0) b = 32'd0;
         if ((op == 4'd5) && ($urandom_range(0, 1) == 0)) b = 32'($urandom_range(1, 40));
         run_op(op, a, b, $urandom_range(0, 3));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
